exe_forwarding_unit: RTL

//  EXE-stage forwarding unit; the consumer end of the ID hazard/forward_en handshake.

---
 rtl/exe_forwarding_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/exe_forwarding_unit.sv
// exe_forwarding_unit
//   EXE-stage forwarding unit. Keeps a shadow pipeline of destination tags
//   across ID/EXE, EXE/MEM and MEM/WB. It drives the operand mux selects for
//   the EXE ALU and exports the EXE/MEM tags back to the ID hazard detector,
//   so that the detector only has to stall on load-use.
//
//   Optional feature macro: FWD_STATS_EN. When it is defined, two saturating
//   forwarding-usage counters are added (fwd_mem_cnt, fwd_wb_cnt).
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   forward_en          global forwarding enable
//   freeze, flush       either one inserts a bubble into EX
//   id_*                tags of the instruction leaving ID
//   exe_dest/wb_en/mem_read   EX-stage tags (to the hazard detector)
//   mem_dest/wb_en            MEM-stage tags
//   sel_src1/sel_src2   00 regfile, 01 MEM ALU result, 10 WB value
//   fwd_mem_cnt/fwd_wb_cnt    (FWD_STATS_EN only) forwarding usage counters
module exe_forwarding_unit #(
  parameter int REG_W = 4
`ifdef FWD_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             freeze,
  input  logic             flush,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  output logic [REG_W-1:0] exe_dest,
  output logic             exe_wb_en,
  output logic             exe_mem_read,
  output logic [REG_W-1:0] mem_dest,
  output logic             mem_wb_en,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0] fwd_mem_cnt,
  output logic [CNT_W-1:0] fwd_wb_cnt
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // EX stage
  logic [REG_W-1:0] ex_src1_reg, ex_src1_next;
  logic [REG_W-1:0] ex_src2_reg, ex_src2_next;
  logic             ex_two_src_reg, ex_two_src_next;
  logic [REG_W-1:0] ex_dest_reg, ex_dest_next;
  logic             ex_wb_en_reg, ex_wb_en_next;
  logic             ex_mem_read_reg, ex_mem_read_next;
  // MEM stage
  logic [REG_W-1:0] mem_dest_reg;
  logic             mem_wb_en_reg;
  logic             mem_mem_read_reg;
  // WB stage
  logic [REG_W-1:0] wb_dest_reg;
  logic             wb_wb_en_reg;

  // A stall or a taken branch turns the slot entering EX into a bubble;
  // MEM and WB keep draining regardless.
  always_comb begin
    ex_src1_next     = '0;
    ex_src2_next     = '0;
    ex_two_src_next  = 1'b0;
    ex_dest_next     = '0;
    ex_wb_en_next    = 1'b0;
    ex_mem_read_next = 1'b0;
    if (!(freeze || flush)) begin
      ex_src1_next     = id_src1;
      ex_src2_next     = id_src2;
      ex_two_src_next  = id_two_src;
      ex_dest_next     = id_dest;
      ex_wb_en_next    = id_wb_en;
      ex_mem_read_next = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_src1_reg      <= '0;
      ex_src2_reg      <= '0;
      ex_two_src_reg   <= 1'b0;
      ex_dest_reg      <= '0;
      ex_wb_en_reg     <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      mem_dest_reg     <= '0;
      mem_wb_en_reg    <= 1'b0;
      mem_mem_read_reg <= 1'b0;
      wb_dest_reg      <= '0;
      wb_wb_en_reg     <= 1'b0;
    end else begin
      ex_src1_reg      <= ex_src1_next;
      ex_src2_reg      <= ex_src2_next;
      ex_two_src_reg   <= ex_two_src_next;
      ex_dest_reg      <= ex_dest_next;
      ex_wb_en_reg     <= ex_wb_en_next;
      ex_mem_read_reg  <= ex_mem_read_next;
      mem_dest_reg     <= ex_dest_reg;
      mem_wb_en_reg    <= ex_wb_en_reg;
      mem_mem_read_reg <= ex_mem_read_reg;
      wb_dest_reg      <= mem_dest_reg;
      wb_wb_en_reg     <= mem_wb_en_reg;
    end
  end

  // A load result is not available from MEM yet, so MEM hits are only taken
  // for ALU producers. MEM is checked first because it holds the youngest value.
  logic mem_fwd_ok;
  logic src1_mem_hit, src1_wb_hit;
  logic src2_mem_hit, src2_wb_hit;

  always_comb begin
    mem_fwd_ok   = forward_en && mem_wb_en_reg && !mem_mem_read_reg;
    src1_mem_hit = mem_fwd_ok && (mem_dest_reg == ex_src1_reg);
    src1_wb_hit  = forward_en && wb_wb_en_reg && (wb_dest_reg == ex_src1_reg);
    src2_mem_hit = ex_two_src_reg && mem_fwd_ok && (mem_dest_reg == ex_src2_reg);
    src2_wb_hit  = ex_two_src_reg && forward_en && wb_wb_en_reg &&
                   (wb_dest_reg == ex_src2_reg);

    sel_src1 = SEL_RF;
    if (src1_mem_hit)     sel_src1 = SEL_MEM;
    else if (src1_wb_hit) sel_src1 = SEL_WB;

    sel_src2 = SEL_RF;
    if (src2_mem_hit)     sel_src2 = SEL_MEM;
    else if (src2_wb_hit) sel_src2 = SEL_WB;
  end

  assign exe_dest     = ex_dest_reg;
  assign exe_wb_en    = ex_wb_en_reg;
  assign exe_mem_read = ex_mem_read_reg;
  assign mem_dest     = mem_dest_reg;
  assign mem_wb_en    = mem_wb_en_reg;

`ifdef FWD_STATS_EN
  // Index 0 counts MEM-path forwards, index 1 counts WB-path forwards. Each
  // counts cycles (not operands) and sticks at all-ones.
  logic [1:0]       cnt_hit;
  logic [CNT_W-1:0] cnt_reg [2];

  always_comb begin
    cnt_hit[0] = (sel_src1 == SEL_MEM) || (sel_src2 == SEL_MEM);
    cnt_hit[1] = (sel_src1 == SEL_WB)  || (sel_src2 == SEL_WB);
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg[gi] <= '0;
        else if (cnt_hit[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign fwd_mem_cnt = cnt_reg[0];
  assign fwd_wb_cnt  = cnt_reg[1];
`endif

endmodule
